// File: rtl/sum_normalize.sv
// Two-stage normalizer: turns a two's-complement fixed-point sum plus base exponent
// into sign / exponent / rounded significand with zero-flush and overflow saturation.
module sum_normalize #(
   parameter int sigWidth   = 4,
   parameter int low_expand = 2,
   parameter int expWidth   = 5
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [sigWidth+4+low_expand-1:0]     in_sum,
   input  logic [expWidth-1:0]                  in_exp,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic                                 out_sign,
   output logic [expWidth-1:0]                  out_exp,
   output logic [sigWidth-1:0]                  out_sig,
   output logic                                 out_zero,
   output logic                                 out_ovf,
   output logic                                 out_valid,
   input  logic                                 out_ready
);

   localparam int W  = sigWidth + 4 + low_expand;
   localparam int U  = sigWidth + low_expand;
   localparam int PW = $clog2(W);
   localparam int EW = expWidth + 2;
   localparam logic signed [EW-1:0] EMAX = EW'((1 << expWidth) - 1);

   logic                s1_valid;
   logic                s1_sign;
   logic [W-1:0]        s1_mag;
   logic                s1_zero;
   logic [expWidth-1:0] s1_exp;

   logic                s1_en;
   logic                s2_en;
   logic [W-1:0]        mag_in;

   logic [PW-1:0]       lead;
   logic [PW-1:0]       shamt;
   logic [W-1:0]        shifted;
   logic [sigWidth-1:0] frac;
   logic                guard;
   logic                sticky;
   logic                round_up;
   logic [sigWidth:0]   rounded;
   logic                carry;
   logic signed [EW-1:0] e_norm;

   logic                nx_sign;
   logic [expWidth-1:0] nx_exp;
   logic [sigWidth-1:0] nx_sig;
   logic                nx_zero;
   logic                nx_ovf;

   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = !s1_valid || !out_valid || out_ready;

   // The most-negative input negates to 2^(W-1), which still fits W unsigned bits.
   assign mag_in = in_sum[W-1] ? (~in_sum + W'(1)) : in_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= '0;
         s1_zero  <= 1'b0;
         s1_exp   <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         s1_sign  <= in_sum[W-1];
         s1_mag   <= mag_in;
         s1_zero  <= (in_sum == '0);
         s1_exp   <= in_exp;
      end
   end

   always_comb begin
      lead = '0;
      for (int i = 0; i < W; i++) begin
         if (s1_mag[i]) lead = PW'(i);
      end
      shamt    = PW'(W - 1) - lead;
      shifted  = s1_mag << shamt;
      frac     = shifted[W-2 -: sigWidth];
      guard    = shifted[W-2-sigWidth];
      sticky   = |shifted[W-3-sigWidth:0];
      round_up = guard && (sticky || frac[0]);
      rounded  = {1'b0, frac} + {{sigWidth{1'b0}}, round_up};
      carry    = rounded[sigWidth];
      e_norm   = $signed({2'b00, s1_exp}) + $signed({{(EW-PW){1'b0}}, lead})
               - $signed(EW'(U)) + $signed({{(EW-1){1'b0}}, carry});
   end

   // Result selection; on a rounding carry the low fraction bits are already zero.
   always_comb begin
      nx_sign = s1_sign;
      nx_exp  = e_norm[expWidth-1:0];
      nx_sig  = rounded[sigWidth-1:0];
      nx_zero = 1'b0;
      nx_ovf  = 1'b0;
      if (s1_zero || !shifted[W-1]) begin
         nx_sign = 1'b0;
         nx_exp  = '0;
         nx_sig  = '0;
         nx_zero = 1'b1;
      end else if (e_norm <= 0) begin
         nx_exp  = '0;
         nx_sig  = '0;
         nx_zero = 1'b1;
      end else if (e_norm > EMAX) begin
         nx_exp  = '1;
         nx_sig  = '0;
         nx_ovf  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_exp   <= '0;
         out_sig   <= '0;
         out_zero  <= 1'b0;
         out_ovf   <= 1'b0;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         out_sign  <= nx_sign;
         out_exp   <= nx_exp;
         out_sig   <= nx_sig;
         out_zero  <= nx_zero;
         out_ovf   <= nx_ovf;
      end
   end

endmodule
